addsub_accumulator: RTL and testbench
=====================================

Name: addsub_accumulator

Overview:
- Sequencing stage directly upstream of the 4-bit signed adder-subtractor datapath. Accepts opcode/operand commands over a valid/ready handshake and feeds the accumulator and operand into an add/sub core (operand B XOR-inverted and carry-in = 1 for subtract).
- Registers the result back into the accumulator and presents it downstream with a per-result overflow flag and a sticky overflow flag.
- Used as the register-file/accumulator front end for the lab ALU experiments.

Parameters:
- WIDTH, 4, datapath width in bits (two's complement); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  stage can accept a command
- in_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLR
- in_data  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_acc  output  WIDTH  accumulator value after the command
- out_ovf  output  1  signed overflow of this command (carry-out XOR MSB carry-in)
- ovf_sticky  output  1  OR of all out_ovf since reset or CLR

Behaviour:
- Reset (synchronous): state IDLE, acc = 0, in_ready = 1, out_valid = 0, out_acc = 0, out_ovf = 0, ovf_sticky = 0, operand registers = 0. Reset asserted in any state aborts the command in flight; nothing is emitted.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready = 1. A handshake (in_valid & in_ready) latches in_op and in_data, then moves to EXEC. Otherwise stays in IDLE.
  - EXEC (1 cycle): in_ready = 0. Computes and commits:
    - LOAD: acc <= in_data
    - ADD: acc <= acc + B
    - SUB: acc <= acc + ~B + 1
    - CLR: acc <= 0 and ovf_sticky cleared
    - Arithmetic wraps modulo 2^WIDTH.
    - out_ovf is set only for ADD/SUB; it is 0 for LOAD/CLR.
    - ovf_sticky |= out_ovf, except on CLR.
    - Next state is DONE.
  - DONE: out_valid = 1. out_acc and out_ovf are held stable until out_ready is sampled high. Then out_valid drops and the next state is IDLE.
- Latency: command accepted at cycle N produces out_valid at N+2. Maximum throughput is one command per 3 cycles.
- Back-pressure: with out_ready low, the block stays in DONE indefinitely, in_ready stays 0, and outputs are unchanged.
- in_valid asserted while in_ready = 0 is ignored. The source must hold its command.
- SUB of the most negative value (e.g. 0 - (-8), WIDTH=4): result wraps to -8 and out_ovf = 1.
- out_acc always equals acc after commit. acc persists across commands.

Optional Feature:
- ACC_SATURATE_EN
  - Defined: on ADD/SUB overflow, acc saturates to the signed maximum (positive overflow) or signed minimum (negative overflow). out_ovf and ovf_sticky are still set.
  - Undefined: acc wraps modulo 2^WIDTH.

Decomposition:
- Package addsub_pkg: opcode constants OP_LOAD/OP_ADD/OP_SUB/OP_CLR, the state encoding constants, and a function returning the signed max/min for WIDTH.
- One sub-module: acc_addsub_core. It is combinational, with inputs a, b, sub and outputs sum, carry, ovf. It implements the ripple add/subtract with b XOR sub and carry-in = sub, and overflow = carry-out XOR carry into the MSB.
- The FSM and registers stay in the top module.

Test Plan:
- Reset, then LOAD 3, then ADD 4 (out_ready = 1) -> out_acc = 7, out_ovf = 0, out_valid asserted 2 cycles after each handshake.
- From acc = 7, ADD 1 -> out_acc = 4'b1000 (-8), out_ovf = 1, ovf_sticky = 1. With ACC_SATURATE_EN: out_acc = 7, flags the same.
- CLR, then SUB 1 -> out_acc = 4'b1111, out_ovf = 0. Then LOAD 8 (-8) and SUB 1 -> out_acc = 7 (wrap) or 8 (saturate), out_ovf = 1.
- Hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid -> out_valid stays 1, out_acc is stable, in_ready = 0, and no command is accepted. Releasing out_ready completes exactly one transfer.
- Assert rst during EXEC of an ADD -> next cycle state is IDLE, acc = 0, out_valid = 0, and no result is emitted.
- CLR after an overflow -> ovf_sticky = 0 and out_acc = 0.

Source files
------------

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the add/sub accumulator front end:
//   - opcode encodings carried on in_op
//   - FSM state encoding used by addsub_accumulator
//   - sat_limit(): signed max/min of a WIDTH-bit two's complement value,
//     used as the clamp values when saturation is built in
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Returns the signed minimum (neg = 1) or maximum (neg = 0) of a w-bit
    // two's complement number, zero-extended into 16 bits (w <= 16).
    function automatic logic [15:0] sat_limit(input int unsigned w, input logic neg);
        logic [31:0] msb_only;
        msb_only = 32'd1 << (w - 1);
        if (neg) begin
            sat_limit = msb_only[15:0];
        end else begin
            sat_limit = 16'(msb_only - 32'd1);
        end
    endfunction

endpackage

// File: rtl/acc_addsub_core.sv
// -----------------------------------------------------------------------------
// acc_addsub_core
// Combinational ripple adder/subtractor: sum = a + (b ^ {sub}) + sub.
// Ports:
//   a     in  WIDTH  first operand (accumulator)
//   b     in  WIDTH  second operand
//   sub   in  1      1 = subtract (invert b, carry-in 1)
//   sum   out WIDTH  result modulo 2^WIDTH
//   carry out 1      carry out of the MSB
//   ovf   out 1      signed overflow = carry out XOR carry into the MSB
// -----------------------------------------------------------------------------
module acc_addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   c;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    // The carry chain is kept in one process so each stage reads the
    // carry produced by the previous iteration.
    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i + 1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
        end
    end

    assign carry = c[WIDTH];
    assign ovf   = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/addsub_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_accumulator
// Command sequencer in front of the signed add/sub core. A command
// (opcode + operand) is accepted in IDLE, executed against the accumulator
// in EXEC, and the result is held in DONE until downstream takes it.
// One command per three cycles at best; result valid two cycles after accept.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   in_valid    in   command valid
//   in_ready    out  stage can accept a command (IDLE only)
//   in_op       in   00 LOAD, 01 ADD, 10 SUB, 11 CLR
//   in_data     in   operand B (WIDTH bits, two's complement)
//   out_valid   out  result valid (DONE only)
//   out_ready   in   downstream accepts result
//   out_acc     out  accumulator after the command
//   out_ovf     out  signed overflow of this command (ADD/SUB only)
//   ovf_sticky  out  OR of out_ovf since reset or the last CLR
//
// Build option:
//   ACC_SATURATE_EN  when defined, ADD/SUB overflow clamps the accumulator to
//                    the signed max/min instead of wrapping; flags unchanged.
// -----------------------------------------------------------------------------
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_ovf,
    output logic             ovf_sticky
);

`ifdef ACC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_limit(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_limit(WIDTH, 1'b1));

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;

    logic [WIDTH-1:0] core_sum;
    logic             core_carry;
    logic             core_ovf;
    logic [WIDTH-1:0] sat_value;
    logic [WIDTH-1:0] arith_result;

    acc_addsub_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a     (acc_q),
        .b     (data_q),
        .sub   (op_q == OP_SUB),
        .sum   (core_sum),
        .carry (core_carry),
        .ovf   (core_ovf)
    );

    // On signed overflow the operands' sign bits agree, so the carry out of
    // the MSB equals that shared sign: carry 0 means both non-negative
    // (overflowed upward), carry 1 means both negative (overflowed downward).
    assign sat_value    = core_carry ? SAT_MIN : SAT_MAX;
    assign arith_result = (SAT_EN && core_ovf) ? sat_value : core_sum;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    data_d  = in_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        acc_d = data_q;
                        ovf_d = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        acc_d    = arith_result;
                        ovf_d    = core_ovf;
                        sticky_d = sticky_q | core_ovf;
                    end
                    default: begin
                        acc_d    = '0;
                        ovf_d    = 1'b0;
                        sticky_d = 1'b0;
                    end
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            data_q   <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_acc    = acc_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
module tb_addsub_accumulator;

    localparam int W    = 4;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_acc;
    logic         out_ovf;
    logic         ovf_sticky;

    addsub_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: accumulator as a plain signed integer.
    int m_acc    = 0;
    bit m_sticky = 1'b0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] acc;
        logic         ovf;
        logic         sticky;
        int           stall;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one command to the model; returns this command's overflow flag.
    function automatic bit model_step(input logic [1:0] op, input logic [W-1:0] d);
        int b;
        int r;
        bit ov;
        b  = int'($signed(d));
        ov = 1'b0;
        case (op)
            2'b00: m_acc = b;
            2'b11: begin
                m_acc    = 0;
                m_sticky = 1'b0;
            end
            default: begin
                r  = (op == 2'b01) ? (m_acc + b) : (m_acc - b);
                ov = (r > MAXV) || (r < MINV);
                if (ov && SAT)        r = (r > MAXV) ? MAXV : MINV;
                else if (r > MAXV)    r = r - (1 << W);
                else if (r < MINV)    r = r + (1 << W);
                m_acc    = r;
                m_sticky = m_sticky | ov;
            end
        endcase
        return ov;
    endfunction

    function automatic logic [W-1:0] model_acc();
        logic [31:0] t;
        t = m_acc;
        return t[W-1:0];
    endfunction

    // Runs one command through the handshake, checks timing/hold behaviour,
    // and returns the values observed in DONE.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data, input int stall,
                           output logic [W-1:0] acc, output logic ovf, output logic sticky);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        @(posedge clk); #1;
        // EXEC: source keeps asserting a different command that must be ignored.
        in_op   = 2'($urandom);
        in_data = W'($urandom);
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("exec_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        acc    = out_acc;
        ovf    = out_ovf;
        sticky = ovf_sticky;
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                in_valid = 1'($urandom);
                in_op    = 2'($urandom);
                in_data  = W'($urandom);
                @(posedge clk); #1;
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_out_acc", 32'(out_acc), 32'(acc));
                check("hold_out_ovf", 32'(out_ovf), 32'(ovf));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        if (stall > 0) begin
            @(posedge clk); #1;
            check("single_transfer", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        m_acc    = 0;
        m_sticky = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r_acc;
        logic         r_ovf;
        logic         r_sticky;
        logic [W-1:0] e_add_ovf;
        logic [W-1:0] e_sub_min;
        logic [W-1:0] e_neg_min;
        logic [1:0]   op;
        logic [W-1:0] d;
        bit           e_ovf;
        int           stall;

        e_add_ovf = SAT ? 4'd7 : 4'd8;   // 7 + 1
        e_sub_min = SAT ? 4'd8 : 4'd7;   // -8 - 1
        e_neg_min = SAT ? 4'd7 : 4'd8;   // 0 - (-8)

        vecs[0]  = '{2'b00, 4'd3,  4'd3,      1'b0, 1'b0, 0};
        vecs[1]  = '{2'b01, 4'd4,  4'd7,      1'b0, 1'b0, 0};
        vecs[2]  = '{2'b01, 4'd1,  e_add_ovf, 1'b1, 1'b1, 0};
        vecs[3]  = '{2'b00, 4'd2,  4'd2,      1'b0, 1'b1, 5};
        vecs[4]  = '{2'b11, 4'd9,  4'd0,      1'b0, 1'b0, 0};
        vecs[5]  = '{2'b10, 4'd1,  4'hF,      1'b0, 1'b0, 0};
        vecs[6]  = '{2'b00, 4'd8,  4'd8,      1'b0, 1'b0, 0};
        vecs[7]  = '{2'b10, 4'd1,  e_sub_min, 1'b1, 1'b1, 0};
        vecs[8]  = '{2'b11, 4'd0,  4'd0,      1'b0, 1'b0, 0};
        vecs[9]  = '{2'b10, 4'd8,  e_neg_min, 1'b1, 1'b1, 3};
        vecs[10] = '{2'b11, 4'd5,  4'd0,      1'b0, 1'b0, 0};

        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;
        rst       = 1'b0;
        apply_reset();

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_acc", 32'(out_acc), 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        check("reset_sticky", 32'(ovf_sticky), 32'd0);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].stall, r_acc, r_ovf, r_sticky);
            e_ovf = model_step(vecs[i].op, vecs[i].data);
            check("vec_acc", 32'(r_acc), 32'(vecs[i].acc));
            check("vec_ovf", 32'(r_ovf), 32'(vecs[i].ovf));
            check("vec_sticky", 32'(r_sticky), 32'(vecs[i].sticky));
            $display("vec %0d op=%0d data=%0h -> acc=%0h ovf=%0b sticky=%0b", i,
                     vecs[i].op, vecs[i].data, r_acc, r_ovf, r_sticky);
        end

        // Reset while an ADD is in EXEC: nothing may be emitted.
        run_cmd(2'b00, 4'd5, 0, r_acc, r_ovf, r_sticky);
        e_ovf = model_step(2'b00, 4'd5);
        check("pre_abort_acc", 32'(r_acc), 32'd5);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_data  = 4'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_in_exec", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        m_acc    = 0;
        m_sticky = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_acc", 32'(out_acc), 32'd0);
        check("abort_sticky", 32'(ovf_sticky), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_emit", 32'(out_valid), 32'd0);
        end
        $display("abort: rst during EXEC -> acc=%0h out_valid=%0b", out_acc, out_valid);

        // Randomized commands against the model
        for (int i = 0; i < 150; i++) begin
            op    = 2'($urandom);
            d     = W'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_cmd(op, d, stall, r_acc, r_ovf, r_sticky);
            e_ovf = model_step(op, d);
            check("rand_acc", 32'(r_acc), 32'(model_acc()));
            check("rand_ovf", 32'(r_ovf), 32'(e_ovf));
            check("rand_sticky", 32'(r_sticky), 32'(m_sticky));
            $display("rand %0d op=%0d data=%0h stall=%0d -> acc=%0h ovf=%0b sticky=%0b",
                     i, op, d, stall, r_acc, r_ovf, r_sticky);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
